// File: rtl/mem_shift_reader_if.sv
// Bus bundle for mem_shift_reader: the write port from the shift-register writer,
// the read request, and the serial output stream with its ready/valid handshake.
interface mem_shift_reader_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4
);
    logic                 wr_en_ff;
    logic [ADDRWIDTH-1:0] addr_ff;
    logic [DATAWIDTH-1:0] wr_data;
    logic                 rd_req;
    logic [ADDRWIDTH-1:0] rd_addr;
    logic                 ser_ready;
    logic                 busy;
    logic                 ser_out;
    logic                 ser_valid;
    logic                 ser_last;
    logic                 done;

    modport master (
        output wr_en_ff, addr_ff, wr_data, rd_req, rd_addr, ser_ready,
        input  busy, ser_out, ser_valid, ser_last, done
    );

    modport slave (
        input  wr_en_ff, addr_ff, wr_data, rd_req, rd_addr, ser_ready,
        output busy, ser_out, ser_valid, ser_last, done
    );
endinterface

// File: rtl/mem_shift_reader.sv
// Small register-file memory whose words are read out MSB first as a serial
// stream with ready/valid flow control. Every output comes straight from a flop.
module mem_shift_reader #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4
) (
    input logic               Clock,
    input logic               Clear,
    mem_shift_reader_if.slave bus
);
    localparam int DEPTH = 2 ** ADDRWIDTH;
    localparam int CW    = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic [DATAWIDTH-1:0] r_mem [DEPTH];
    logic [ADDRWIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATAWIDTH-1:0] r_shift, w_shift_nxt, w_load_word;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic                 r_busy, r_ser_out, r_ser_valid, r_ser_last, r_done;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (bus.wr_en_ff) begin
            r_mem[bus.addr_ff] <= bus.wr_data;
        end
    end

    // A write landing on the captured address in the LOAD cycle is forwarded,
    // since the array itself only updates at the end of that cycle.
    assign w_load_word = (bus.wr_en_ff && (bus.addr_ff == r_addr)) ? bus.wr_data
                                                                    : r_mem[r_addr];

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.rd_req) begin
                    w_addr_nxt  = bus.rd_addr;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_shift_nxt = w_load_word;
                w_cnt_nxt   = CW'(DATAWIDTH - 1);
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (bus.ser_ready) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_shift_nxt = r_shift << 1;
                        w_cnt_nxt   = r_cnt - 1'b1;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they line up with it.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_ser_out   <= (w_state_nxt == SHIFT) && w_shift_nxt[DATAWIDTH-1];
            r_ser_valid <= (w_state_nxt == SHIFT);
            r_ser_last  <= (w_state_nxt == SHIFT) && (w_cnt_nxt == '0);
            r_done      <= (w_state_nxt == DONE);
        end
    end

    assign bus.busy      = r_busy;
    assign bus.ser_out   = r_ser_out;
    assign bus.ser_valid = r_ser_valid;
    assign bus.ser_last  = r_ser_last;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_mem_shift_reader.sv
// Directed bench for mem_shift_reader: cycle-exact serial readout, stalls,
// LOAD-cycle bypass, snapshot/busy behaviour, async clear and the top address.
module tb_mem_shift_reader;
    logic Clock;
    logic Clear;
    int   vectors = 0;
    int   errs    = 0;

    mem_shift_reader_if #(.DATAWIDTH(8), .ADDRWIDTH(4)) bus ();

    mem_shift_reader #(.DATAWIDTH(8), .ADDRWIDTH(4)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  bus.busy,      1'b0);
        chk({tag, "_out"},   bus.ser_out,   1'b0);
        chk({tag, "_valid"}, bus.ser_valid, 1'b0);
        chk({tag, "_last"},  bus.ser_last,  1'b0);
        chk({tag, "_done"},  bus.done,      1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.wr_en_ff = 1'b1;
        bus.addr_ff  = a;
        bus.wr_data  = d;
        tick();
        bus.wr_en_ff = 1'b0;
    endtask

    // wmode: 0 none, 1 write with the request, 2 write in LOAD, 3 write + rd_req(7) at bit 2
    task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp,
                      input int stall_bit, input int wmode, input logic [7:0] wd);
        bus.rd_req  = 1'b1;
        bus.rd_addr = a;
        if (wmode == 1) begin
            bus.wr_en_ff = 1'b1; bus.addr_ff = a; bus.wr_data = wd;
        end
        tick();
        bus.rd_req   = 1'b0;
        bus.wr_en_ff = 1'b0;
        chk({tag, "_load_busy"},  bus.busy,      1'b1);
        chk({tag, "_load_valid"}, bus.ser_valid, 1'b0);
        if (wmode == 2) begin
            bus.wr_en_ff = 1'b1; bus.addr_ff = a; bus.wr_data = wd;
        end
        tick();
        bus.wr_en_ff = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_b%0d_valid", tag, k), bus.ser_valid, 1'b1);
            chk($sformatf("%s_b%0d_out", tag, k),   bus.ser_out,   exp[7-k]);
            chk($sformatf("%s_b%0d_last", tag, k),  bus.ser_last,  (k == 7));
            chk($sformatf("%s_b%0d_done", tag, k),  bus.done,      1'b0);
            if (k == stall_bit) begin
                bus.ser_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk($sformatf("%s_stall%0d_out", tag, s),   bus.ser_out,   exp[7-k]);
                    chk($sformatf("%s_stall%0d_valid", tag, s), bus.ser_valid, 1'b1);
                    chk($sformatf("%s_stall%0d_last", tag, s),  bus.ser_last,  1'b0);
                end
                bus.ser_ready = 1'b1;
            end
            if (wmode == 3 && k == 2) begin
                bus.wr_en_ff = 1'b1; bus.addr_ff = a; bus.wr_data = wd;
                bus.rd_req   = 1'b1; bus.rd_addr = 4'd7;
            end
            tick();
            bus.wr_en_ff = 1'b0;
            bus.rd_req   = 1'b0;
        end
        chk({tag, "_done"},       bus.done,      1'b1);
        chk({tag, "_done_valid"}, bus.ser_valid, 1'b0);
        chk({tag, "_done_out"},   bus.ser_out,   1'b0);
        chk({tag, "_done_busy"},  bus.busy,      1'b1);
        tick();
        chk_idle({tag, "_after"});
    endtask

    initial begin
        Clear         = 1'b0;
        bus.wr_en_ff  = 1'b0;
        bus.addr_ff   = '0;
        bus.wr_data   = '0;
        bus.rd_req    = 1'b0;
        bus.rd_addr   = '0;
        bus.ser_ready = 1'b1;
        #12;
        chk_idle("reset");
        @(negedge Clock);
        Clear = 1'b1;
        tick();
        chk_idle("post_reset");

        // Basic readout, no stalls
        wr(4'd3, 8'hA5);
        rd("a5", 4'd3, 8'hA5, -1, 0, 8'h00);

        // Stall three cycles on the second bit
        wr(4'd4, 8'h3C);
        rd("3c_stall", 4'd4, 8'h3C, 1, 0, 8'h00);

        // LOAD-cycle bypass
        wr(4'd5, 8'h00);
        rd("bypass", 4'd5, 8'hFF, -1, 2, 8'hFF);

        // Write and request in the same IDLE cycle
        rd("same_cyc", 4'd9, 8'hC3, -1, 1, 8'hC3);

        // Snapshot and ignored request while busy
        wr(4'd2, 8'h81);
        wr(4'd7, 8'h77);
        rd("snap", 4'd2, 8'h81, -1, 3, 8'h00);
        tick();
        chk_idle("no_queue1");
        tick();
        chk_idle("no_queue2");
        rd("snap_reread", 4'd2, 8'h00, -1, 0, 8'h00);

        // Asynchronous clear mid-transfer
        bus.rd_req  = 1'b1;
        bus.rd_addr = 4'd3;
        tick();
        bus.rd_req = 1'b0;
        tick();
        tick();
        chk("abort_pre_valid", bus.ser_valid, 1'b1);
        #2;
        Clear = 1'b0;
        #1;
        chk_idle("abort");
        tick();
        chk_idle("abort_hold");
        @(negedge Clock);
        Clear = 1'b1;
        tick();
        chk_idle("abort_release");
        rd("cleared", 4'd3, 8'h00, -1, 0, 8'h00);

        // Top address
        wr(4'd15, 8'h5A);
        rd("top", 4'd15, 8'h5A, -1, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
